// File: rtl/decode_pipe_if.sv
// Fetch/decode/execute bundle around the decode stage: fetch payload, writeback port,
// EX handshake and the ID/EX outputs. The master drives the stage, the slave is the stage.
interface decode_pipe_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int CTRL_W = 12
);
    logic              if_valid;
    logic              id_ready;
    logic [SEL_W-1:0]  rs_sel;
    logic [SEL_W-1:0]  rt_sel;
    logic [SEL_W-1:0]  rd_sel;
    logic              uses_rs;
    logic              uses_rt;
    logic [10:0]       imm_raw;
    logic [1:0]        imm_mode;
    logic              sign_ext;
    logic [DATA_W-1:0] pc_next;
    logic [CTRL_W-1:0] ctrl_in;
    logic              reg_write_in;
    logic              mem_read_in;
    logic              wb_en;
    logic [SEL_W-1:0]  wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              ex_ready;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_br_target;
    logic [SEL_W-1:0]  ex_rs_sel;
    logic [SEL_W-1:0]  ex_rt_sel;
    logic [SEL_W-1:0]  ex_rd_sel;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              err;

    modport master (
        output if_valid, rs_sel, rt_sel, rd_sel, uses_rs, uses_rt, imm_raw, imm_mode,
               sign_ext, pc_next, ctrl_in, reg_write_in, mem_read_in,
               wb_en, wb_sel, wb_data, ex_ready, flush,
        input  id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
               ex_rs_sel, ex_rt_sel, ex_rd_sel, ex_ctrl, ex_reg_write, ex_mem_read, err
    );

    modport slave (
        input  if_valid, rs_sel, rt_sel, rd_sel, uses_rs, uses_rt, imm_raw, imm_mode,
               sign_ext, pc_next, ctrl_in, reg_write_in, mem_read_in,
               wb_en, wb_sel, wb_data, ex_ready, flush,
        output id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
               ex_rs_sel, ex_rt_sel, ex_rd_sel, ex_ctrl, ex_reg_write, ex_mem_read, err
    );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage with register file, immediate extension, branch-target adder, load-use
// stall and ID/EX register. Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback into reads.
module decode_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int CTRL_W   = 12
) (
    input  logic         clk,
    input  logic         rst,
    decode_pipe_if.slave bus
);
    localparam logic [SEL_W:0] LIM = (SEL_W+1)'(NUM_REGS);

    function automatic logic signed [DATA_W-1:0] ext_imm(input logic [10:0] raw,
                                                         input logic [1:0]  mode,
                                                         input logic        sx);
        logic signed [DATA_W-1:0] v;
        case (mode)
            2'b00:   v = {{(DATA_W-5){sx & raw[4]}}, raw[4:0]};
            2'b01:   v = {{(DATA_W-8){sx & raw[7]}}, raw[7:0]};
            2'b10:   v = {{(DATA_W-11){raw[10]}}, raw[10:0]};
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic                     r_err;

    logic                     r_vld_p1;
    logic [DATA_W-1:0]        r_rs_data_p1;
    logic [DATA_W-1:0]        r_rt_data_p1;
    logic [DATA_W-1:0]        r_imm_p1;
    logic [DATA_W-1:0]        r_br_target_p1;
    logic [SEL_W-1:0]         r_rs_sel_p1;
    logic [SEL_W-1:0]         r_rt_sel_p1;
    logic [SEL_W-1:0]         r_rd_sel_p1;
    logic [CTRL_W-1:0]        r_ctrl_p1;
    logic                     r_reg_write_p1;
    logic                     r_mem_read_p1;

    logic                     w_rs_oob;
    logic                     w_rt_oob;
    logic                     w_wb_oob;
    logic [DATA_W-1:0]        w_rs_data_p0;
    logic [DATA_W-1:0]        w_rt_data_p0;
    logic signed [DATA_W-1:0] w_imm_p0;
    logic [DATA_W-1:0]        w_br_target_p0;
    logic                     w_advance;
    logic                     w_hazard;
    logic                     w_load;

    assign w_rs_oob = {1'b0, bus.rs_sel} >= LIM;
    assign w_rt_oob = {1'b0, bus.rt_sel} >= LIM;
    assign w_wb_oob = {1'b0, bus.wb_sel} >= LIM;

    // ---- p0: decode (register read, immediate, branch target, hazard) ----
    always_comb begin
        w_rs_data_p0 = '0;
        w_rt_data_p0 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rs_sel == SEL_W'(i)) w_rs_data_p0 = r_regs[i];
            if (bus.rt_sel == SEL_W'(i)) w_rt_data_p0 = r_regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_en && !w_wb_oob && (bus.wb_sel == bus.rs_sel)) w_rs_data_p0 = bus.wb_data;
        if (bus.wb_en && !w_wb_oob && (bus.wb_sel == bus.rt_sel)) w_rt_data_p0 = bus.wb_data;
`endif
    end

    assign w_imm_p0       = ext_imm(bus.imm_raw, bus.imm_mode, bus.sign_ext);
    assign w_br_target_p0 = bus.pc_next + $unsigned(w_imm_p0);

    // A load in ID/EX whose destination feeds this instruction forces one bubble.
    assign w_advance = bus.ex_ready | ~r_vld_p1;
    assign w_hazard  = bus.if_valid & r_vld_p1 & r_mem_read_p1 & r_reg_write_p1 &
                       ((bus.uses_rs & (bus.rs_sel == r_rd_sel_p1)) |
                        (bus.uses_rt & (bus.rt_sel == r_rd_sel_p1)));
    assign w_load    = w_advance & ~w_hazard & bus.if_valid;
    assign bus.id_ready = w_advance & ~w_hazard;

    // Writeback never stalls: it ignores flush and the ID/EX handshake entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wb_sel == SEL_W'(i)) r_regs[i] <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((bus.wb_en && w_wb_oob) || (bus.if_valid && (w_rs_oob || w_rt_oob))) begin
            r_err <= 1'b1;
        end
    end

    // ---- p1: ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_rs_data_p1   <= '0;
            r_rt_data_p1   <= '0;
            r_imm_p1       <= '0;
            r_br_target_p1 <= '0;
            r_rs_sel_p1    <= '0;
            r_rt_sel_p1    <= '0;
            r_rd_sel_p1    <= '0;
            r_ctrl_p1      <= '0;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_load) begin
            r_vld_p1       <= 1'b1;
            r_rs_data_p1   <= w_rs_data_p0;
            r_rt_data_p1   <= w_rt_data_p0;
            r_imm_p1       <= $unsigned(w_imm_p0);
            r_br_target_p1 <= w_br_target_p0;
            r_rs_sel_p1    <= bus.rs_sel;
            r_rt_sel_p1    <= bus.rt_sel;
            r_rd_sel_p1    <= bus.rd_sel;
            r_ctrl_p1      <= bus.ctrl_in;
            r_reg_write_p1 <= bus.reg_write_in;
            r_mem_read_p1  <= bus.mem_read_in;
        end else if (w_advance) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.ex_valid     = r_vld_p1;
    assign bus.ex_rs_data   = r_rs_data_p1;
    assign bus.ex_rt_data   = r_rt_data_p1;
    assign bus.ex_imm       = r_imm_p1;
    assign bus.ex_br_target = r_br_target_p1;
    assign bus.ex_rs_sel    = r_rs_sel_p1;
    assign bus.ex_rt_sel    = r_rt_sel_p1;
    assign bus.ex_rd_sel    = r_rd_sel_p1;
    assign bus.ex_ctrl      = r_ctrl_p1;
    assign bus.ex_reg_write = r_reg_write_p1;
    assign bus.ex_mem_read  = r_mem_read_p1;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios on an 8-register and a 6-register instance,
// then randomized traffic checked against a behavioural model of the stage.
module tb_decode_pipe;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    decode_pipe_if #(.DATA_W(16), .SEL_W(3), .CTRL_W(12)) b8 ();
    decode_pipe_if #(.DATA_W(16), .SEL_W(3), .CTRL_W(12)) b6 ();

    decode_pipe #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .CTRL_W(12)) dut8 (
        .clk(clk), .rst(rst), .bus(b8.slave));
    decode_pipe #(.DATA_W(16), .NUM_REGS(6), .SEL_W(3), .CTRL_W(12)) dut6 (
        .clk(clk), .rst(rst), .bus(b6.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit vld;
        int rs_data, rt_data, imm, br, rs, rt, rd, ctrl;
        bit rw, mr;
    } idex_t;

    int    m_regs [8];
    idex_t m;
    idex_t nxt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        b8.if_valid = 0; b8.rs_sel = 0; b8.rt_sel = 0; b8.rd_sel = 0;
        b8.uses_rs = 0; b8.uses_rt = 0; b8.imm_raw = 0; b8.imm_mode = 0; b8.sign_ext = 0;
        b8.pc_next = 0; b8.ctrl_in = 0; b8.reg_write_in = 0; b8.mem_read_in = 0;
        b8.wb_en = 0; b8.wb_sel = 0; b8.wb_data = 0; b8.ex_ready = 1; b8.flush = 0;
    endtask

    task automatic idle6();
        b6.if_valid = 0; b6.rs_sel = 0; b6.rt_sel = 0; b6.rd_sel = 0;
        b6.uses_rs = 0; b6.uses_rt = 0; b6.imm_raw = 0; b6.imm_mode = 0; b6.sign_ext = 0;
        b6.pc_next = 0; b6.ctrl_in = 0; b6.reg_write_in = 0; b6.mem_read_in = 0;
        b6.wb_en = 0; b6.wb_sel = 0; b6.wb_data = 0; b6.ex_ready = 1; b6.flush = 0;
    endtask

    // Immediate value as a number, then reduced modulo 2^16.
    function automatic int model_imm(input int raw, input int mode, input bit sx);
        int v;
        case (mode)
            0:       begin v = raw % 32;   if (sx && v >= 16)   v -= 32;   end
            1:       begin v = raw % 256;  if (sx && v >= 128)  v -= 256;  end
            2:       begin v = raw % 2048; if (v >= 1024)       v -= 2048; end
            default: v = 0;
        endcase
        return (v + 65536) % 65536;
    endfunction

    function automatic int model_read(input int sel, input bit wen, input int wsel, input int wdata);
`ifdef REGFILE_BYPASS_EN
        if (wen && wsel == sel) return wdata;
`endif
        return m_regs[sel];
    endfunction

    initial begin
        bit m_adv, m_haz;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        idle8();
        idle6();
        #1;
        chk("reset_ex_valid", b8.ex_valid, 0);
        chk("reset_err", b8.err, 0);
        chk("reset_id_ready", b8.id_ready, 1);
        chk("reset_ex_rs_data", b8.ex_rs_data, 0);
        chk("reset_ex_ctrl", b8.ex_ctrl, 0);
        tick();
        rst = 1'b0;

        // Write R3, then decode reading R3
        b8.wb_en = 1; b8.wb_sel = 3; b8.wb_data = 16'h1234;
        tick();
        b8.wb_en = 0;
        b8.if_valid = 1; b8.uses_rs = 1; b8.rs_sel = 3; b8.rd_sel = 1;
        b8.ctrl_in = 12'hABC; b8.reg_write_in = 1;
        #1;
        chk("accept_id_ready", b8.id_ready, 1);
        chk("pre_accept_ex_valid", b8.ex_valid, 0);
        tick();
        chk("r3_ex_valid", b8.ex_valid, 1);
        chk("r3_ex_rs_data", b8.ex_rs_data, 16'h1234);
        chk("r3_ex_ctrl", b8.ex_ctrl, 12'hABC);
        chk("r3_ex_rd_sel", b8.ex_rd_sel, 1);

        // Same-cycle writeback R5 while decoding rs=5
        b8.rs_sel = 5; b8.wb_en = 1; b8.wb_sel = 5; b8.wb_data = 16'hBEEF;
        tick();
        b8.wb_en = 0;
`ifdef REGFILE_BYPASS_EN
        chk("wb_same_cycle", b8.ex_rs_data, 16'hBEEF);
`else
        chk("wb_same_cycle", b8.ex_rs_data, 16'h0000);
`endif
        tick();
        chk("wb_next_cycle", b8.ex_rs_data, 16'hBEEF);

        // Load-use: load to R2, consumer reads rt=2
        b8.uses_rs = 0; b8.uses_rt = 0; b8.mem_read_in = 1; b8.reg_write_in = 1; b8.rd_sel = 2;
        tick();
        chk("load_ex_mem_read", b8.ex_mem_read, 1);
        chk("load_ex_rd_sel", b8.ex_rd_sel, 2);
        b8.mem_read_in = 0; b8.uses_rt = 1; b8.rt_sel = 2; b8.rd_sel = 4; b8.ctrl_in = 12'h055;
        #1;
        chk("hazard_id_ready", b8.id_ready, 0);
        tick();
        chk("bubble_ex_valid", b8.ex_valid, 0);
        chk("after_bubble_id_ready", b8.id_ready, 1);
        tick();
        chk("stalled_ex_valid", b8.ex_valid, 1);
        chk("stalled_ex_rt_sel", b8.ex_rt_sel, 2);
        chk("stalled_ex_rd_sel", b8.ex_rd_sel, 4);
        chk("stalled_ex_ctrl", b8.ex_ctrl, 12'h055);
        chk("stalled_ex_mem_read", b8.ex_mem_read, 0);

        // Immediates and branch targets
        b8.uses_rt = 0; b8.reg_write_in = 0;
        b8.imm_mode = 2'b01; b8.imm_raw = 11'h0F0; b8.sign_ext = 1; b8.pc_next = 16'h0010;
        tick();
        chk("imm8_sx", b8.ex_imm, 16'hFFF0);
        chk("br_wrap", b8.ex_br_target, 16'h0000);
        b8.imm_mode = 2'b00; b8.imm_raw = 11'h010; b8.sign_ext = 0;
        tick();
        chk("imm5_zx", b8.ex_imm, 16'h0010);
        chk("br_imm5", b8.ex_br_target, 16'h0020);
        b8.sign_ext = 1;
        tick();
        chk("imm5_sx", b8.ex_imm, 16'hFFF0);
        b8.imm_mode = 2'b10; b8.imm_raw = 11'h400; b8.sign_ext = 0;
        tick();
        chk("imm11", b8.ex_imm, 16'hFC00);
        b8.imm_mode = 2'b11; b8.imm_raw = 11'h7FF;
        tick();
        chk("imm_reserved", b8.ex_imm, 16'h0000);

        // EX back-pressure for 3 cycles, then flush during the stall
        b8.ctrl_in = 12'h777;
        tick();
        b8.ex_ready = 0; b8.ctrl_in = 12'h111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_id_ready", b8.id_ready, 0);
            tick();
            chk("stall_ex_valid", b8.ex_valid, 1);
            chk("stall_ex_ctrl", b8.ex_ctrl, 12'h777);
        end
        b8.flush = 1;
        tick();
        chk("flush_ex_valid", b8.ex_valid, 0);
        b8.flush = 0; b8.ex_ready = 1;
        idle8();

        // Six-register instance: out-of-range write, then async reset mid-stall
        b6.wb_en = 1; b6.wb_sel = 5; b6.wb_data = 16'h5555;
        tick();
        chk("n6_err_clear", b6.err, 0);
        b6.wb_sel = 7; b6.wb_data = 16'hFFFF;
        tick();
        b6.wb_en = 0;
        chk("n6_wb_oob_err", b6.err, 1);
        chk("n8_err_untouched", b8.err, 0);
        b6.if_valid = 1; b6.rs_sel = 5; b6.rt_sel = 0;
        tick();
        chk("n6_r5_kept", b6.ex_rs_data, 16'h5555);
        chk("n6_r0_kept", b6.ex_rt_data, 16'h0000);
        chk("n6_err_sticky", b6.err, 1);
        b6.ex_ready = 0;
        tick();
        tick();
        chk("n6_stall_ex_valid", b6.ex_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", b6.ex_valid, 0);
        chk("async_rst_err", b6.err, 0);
        chk("async_rst_rs_data", b6.ex_rs_data, 0);
        tick();
        rst = 1'b0;
        b6.ex_ready = 1; b6.rs_sel = 6;
        tick();
        chk("n6_rd_oob_err", b6.err, 1);
        chk("n6_rd_oob_data", b6.ex_rs_data, 0);
        idle6();
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m = '{default: 0};
        for (int c = 0; c < 400; c++) begin
            b8.if_valid     = ($urandom % 4) != 0;
            b8.rs_sel       = 3'($urandom % 4);
            b8.rt_sel       = 3'($urandom % 4);
            b8.rd_sel       = 3'($urandom % 4);
            b8.uses_rs      = 1'($urandom);
            b8.uses_rt      = 1'($urandom);
            b8.imm_raw      = 11'($urandom);
            b8.imm_mode     = 2'($urandom);
            b8.sign_ext     = 1'($urandom);
            b8.pc_next      = 16'($urandom);
            b8.ctrl_in      = 12'($urandom);
            b8.reg_write_in = 1'($urandom);
            b8.mem_read_in  = ($urandom % 3) == 0;
            b8.wb_en        = 1'($urandom);
            b8.wb_sel       = 3'($urandom % 4);
            b8.wb_data      = 16'($urandom);
            b8.ex_ready     = ($urandom % 4) != 0;
            b8.flush        = ($urandom % 16) == 0;
            #3;
            m_adv = b8.ex_ready || !m.vld;
            m_haz = b8.if_valid && m.vld && m.mr && m.rw &&
                    ((b8.uses_rs && int'(b8.rs_sel) == m.rd) ||
                     (b8.uses_rt && int'(b8.rt_sel) == m.rd));
            chk("rnd_id_ready", b8.id_ready, 32'(m_adv && !m_haz));
            nxt = m;
            if (b8.flush) begin
                nxt.vld = 0;
            end else if (m_adv && !m_haz && b8.if_valid) begin
                nxt.vld     = 1;
                nxt.rs_data = model_read(int'(b8.rs_sel), b8.wb_en, int'(b8.wb_sel), int'(b8.wb_data));
                nxt.rt_data = model_read(int'(b8.rt_sel), b8.wb_en, int'(b8.wb_sel), int'(b8.wb_data));
                nxt.imm     = model_imm(int'(b8.imm_raw), int'(b8.imm_mode), b8.sign_ext);
                nxt.br      = (int'(b8.pc_next) + nxt.imm) % 65536;
                nxt.rs      = int'(b8.rs_sel);
                nxt.rt      = int'(b8.rt_sel);
                nxt.rd      = int'(b8.rd_sel);
                nxt.ctrl    = int'(b8.ctrl_in);
                nxt.rw      = b8.reg_write_in;
                nxt.mr      = b8.mem_read_in;
            end else if (m_adv) begin
                nxt.vld = 0;
            end
            if (b8.wb_en) m_regs[int'(b8.wb_sel)] = int'(b8.wb_data);
            tick();
            m = nxt;
            chk("rnd_ex_valid", b8.ex_valid, 32'(m.vld));
            if (m.vld) begin
                chk("rnd_rs_data", b8.ex_rs_data, m.rs_data);
                chk("rnd_rt_data", b8.ex_rt_data, m.rt_data);
                chk("rnd_imm", b8.ex_imm, m.imm);
                chk("rnd_br", b8.ex_br_target, m.br);
                chk("rnd_rs_sel", b8.ex_rs_sel, m.rs);
                chk("rnd_rt_sel", b8.ex_rt_sel, m.rt);
                chk("rnd_rd_sel", b8.ex_rd_sel, m.rd);
                chk("rnd_ctrl", b8.ex_ctrl, m.ctrl);
                chk("rnd_reg_write", b8.ex_reg_write, 32'(m.rw));
                chk("rnd_mem_read", b8.ex_mem_read, 32'(m.mr));
            end
        end
        chk("rnd_err", b8.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised decode stage with a built-in ID/EX pipeline register for the pipelined processor.
- Contains:
  - the register file (NUM_REGS x DATA_W),
  - immediate extension,
  - branch-target adder,
  - load-use hazard detection with bubble insertion,
  - a valid/ready handshake toward fetch and execute.
- Control decoding stays in the external control unit; its bundle passes through opaquely.

Parameters:
- DATA_W, 16, datapath and register width.
- NUM_REGS, 8, number of architectural registers.
- SEL_W, 3, register select width; must satisfy 2^SEL_W >= NUM_REGS.
- CTRL_W, 12, width of the opaque control bundle passed to EX.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetch presents an instruction
- id_ready  out  1  decode accepts the instruction this cycle
- rs_sel, rt_sel, rd_sel  in  SEL_W each  source and destination register selects
- uses_rs, uses_rt  in  1 each  instruction reads rs / rt
- imm_raw  in  11  raw immediate bits
- imm_mode  in  2  immediate width: 00 = 5b, 01 = 8b, 10 = 11b, 11 = reserved
- sign_ext  in  1  sign-extend 5b/8b immediates
- pc_next  in  DATA_W  PC+2 of the instruction
- ctrl_in  in  CTRL_W  control bundle
- reg_write_in, mem_read_in  in  1 each  instruction writes a register / is a load
- wb_en  in  1  writeback enable
- wb_sel  in  SEL_W  writeback register
- wb_data  in  DATA_W  writeback data
- ex_ready  in  1  EX accepts the current ID/EX contents
- flush  in  1  squash ID/EX (taken branch)
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_rs_data, ex_rt_data  out  DATA_W  register operands
- ex_imm  out  DATA_W  extended immediate
- ex_br_target  out  DATA_W  pc_next + ex_imm
- ex_rs_sel, ex_rt_sel, ex_rd_sel  out  SEL_W  latched selects
- ex_ctrl  out  CTRL_W  latched control bundle
- ex_reg_write, ex_mem_read  out  1 each  latched flags
- err  out  1  sticky error flag

Behaviour:
- Reset values:
  - all registers 0; all ex_* outputs 0; ex_valid=0; err=0.
  - id_ready during reset follows its combinational formula (true, since ex_valid=0).
- Immediate extension:
  - mode 00: imm_raw[4:0], sign- or zero-extended per sign_ext.
  - mode 01: imm_raw[7:0], sign- or zero-extended per sign_ext.
  - mode 10: imm_raw[10:0], always sign-extended.
  - mode 11: result 0.
- Branch target: pc_next + extended immediate, modulo 2^DATA_W, carry discarded.
- Hazard and handshake signals:
  - advance = ex_ready | ~ex_valid.
  - hazard = if_valid & ex_valid & ex_mem_read & ex_reg_write & ((uses_rs & rs_sel==ex_rd_sel) | (uses_rt & rt_sel==ex_rd_sel)).
  - id_ready = advance & ~hazard, combinational.
- Each clock edge, in priority order:
  - flush: ex_valid<=0; the presented instruction is dropped, since fetch is flushed too.
  - else if advance & ~hazard & if_valid: load the full payload and set ex_valid<=1.
  - else if advance: ex_valid<=0 (bubble or idle); payload may hold.
  - else: hold all ID/EX contents.
- Load-use latency: exactly one bubble. The stalled instruction enters ID/EX on the cycle after the load leaves.
- Register file:
  - 2 combinational reads, 1 synchronous write on wb_en.
  - Write to a select >= NUM_REGS is ignored and sets err.
  - A read of a select >= NUM_REGS returns 0 and sets err when if_valid.
  - err clears only on rst.
- Writeback is independent of stall and flush; it is never blocked.
- rst asserted mid-operation clears state immediately, regardless of the clock.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when wb_en and wb_sel equals the rs/rt select in the same cycle, the read returns wb_data, so ID/EX captures the new value.
- Undefined: reads return the pre-write register contents. Writeback-to-decode forwarding then belongs to the external forwarding unit.

Test Plan:
- Reset, then write R3=0x1234; next cycle decode with rs_sel=3 -> ex_rs_data=0x1234, ex_valid=1 one cycle after acceptance.
- Same-cycle wb R5=0xBEEF with rs_sel=5:
  - REGFILE_BYPASS_EN defined -> ex_rs_data=0xBEEF.
  - undefined -> old value 0x0000.
- Load to R2 in ID/EX (ex_mem_read=1, ex_rd_sel=2), next instruction uses_rt with rt_sel=2 -> id_ready=0 for 1 cycle, ex_valid=0 bubble, then instruction latched.
- Immediates:
  - imm_mode=01, imm_raw=0x0F0, sign_ext=1, pc_next=0x0010 -> ex_imm=0xFFF0, ex_br_target=0x0000 (wrap).
  - imm_mode=00, imm_raw=0x010, sign_ext=0 -> ex_imm=0x0010.
- ex_ready=0 for 3 cycles with if_valid=1 -> ID/EX contents stable, id_ready=0; flush asserted during the stall -> ex_valid=0 next cycle.
- NUM_REGS=6, wb_sel=7 with wb_en=1 -> no register changes, err=1 until rst; rst pulse mid-stall -> ex_valid=0 and err=0 immediately.
